// File: rtl/paridade_stream.sv
// -----------------------------------------------------------------------------
// paridade_stream
//
// Purpose:
//   Single-stage streaming parity checker. Each accepted word carries a
//   payload plus one parity bit. The block strips the parity bit and
//   registers the payload together with an error flag. It also keeps
//   error statistics: a sticky flag and an optional saturating counter.
//   The valid/ready handshake has one output register and no stall
//   bubble.
//
// Parameters:
//   DATA_W  - payload width in bits (>= 1)
//   PAR_ODD - 0: even parity, 1: odd parity
//   CNT_W   - error counter width in bits (>= 1)
//
// Configuration macro:
//   PARIDADE_STREAM_CONTADOR_EN - when defined, the saturating error
//   counter is built. When undefined, cont_erros is tied to 0 and the
//   port list stays the same.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   upstream word valid
//   in_dado      in   [DATA_W] parity bit, [DATA_W-1:0] payload
//   in_ready     out  block can accept a word this cycle
//   out_valid    out  checked word available
//   out_dado     out  payload of the checked word
//   out_erro     out  parity-error flag for the word on out_dado
//   out_ready    in   downstream accepts the output word
//   clr_erros    in   synchronous clear of error statistics
//   erro_sticky  out  set once any accepted word failed parity
//   cont_erros   out  saturating count of erroneous accepted words
// -----------------------------------------------------------------------------
module paridade_stream #(
   parameter int DATA_W  = 8,
   parameter int PAR_ODD = 0,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W:0]   in_dado,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_dado,
   output logic              out_erro,
   input  logic              out_ready,
   input  logic              clr_erros,
   output logic              erro_sticky,
   output logic [CNT_W-1:0]  cont_erros
);

   logic              r_valid;
   logic [DATA_W-1:0] r_dado;
   logic              r_erro;
   logic              r_sticky;

   logic              w_accept;
   logic              w_erro_in;
   logic              w_novo_erro;

   // The reduction XOR over payload and parity bit is 0 for a good
   // even-parity word. XORing with the mode bit makes the same
   // expression serve odd parity.
   assign w_erro_in   = (^in_dado) ^ (PAR_ODD != 0);

   // Ready while the output register is empty or is being drained this
   // cycle. Under reset r_valid is 0, so this reads 1.
   assign in_ready    = !r_valid || out_ready;
   assign w_accept    = in_valid && in_ready;
   assign w_novo_erro = w_accept && w_erro_in;

   // Output register. Payload and flag load only on acceptance, so they
   // hold while the word is stalled.
   // NOTE: every register in this block is written with non-blocking
   // assignments, so all updates use the values from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: data registers are reset too, not only the valid bit,
         // because the outputs must read 0 while reset is active.
         r_valid <= 1'b0;
         r_dado  <= '0;
         r_erro  <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_dado  <= in_dado[DATA_W-1:0];
         r_erro  <= w_erro_in;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   // Sticky error flag. A clear and a new error in the same cycle leave
   // the flag set: the clear is applied first, then the new error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 1'b0;
      end else if (clr_erros) begin
         r_sticky <= w_novo_erro;
      end else if (w_novo_erro) begin
         r_sticky <= 1'b1;
      end
   end

`ifdef PARIDADE_STREAM_CONTADOR_EN
   logic [CNT_W-1:0] r_cont;

   // Saturating error counter. Clearing in the same cycle as a new
   // error restarts the count at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cont <= '0;
      end else if (clr_erros) begin
         r_cont <= CNT_W'(w_novo_erro);
      end else if (w_novo_erro && (r_cont != '1)) begin
         r_cont <= r_cont + CNT_W'(1);
      end
   end

   assign cont_erros = r_cont;
`else
   assign cont_erros = '0;
`endif

   assign out_valid   = r_valid;
   assign out_dado    = r_dado;
   assign out_erro    = r_erro;
   assign erro_sticky = r_sticky;

endmodule

// File: tb/tb_paridade_stream.sv
module tb_paridade_stream;

   localparam int DATA_W  = 8;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic [DATA_W:0]   in_dado;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_dado;
   logic              out_erro;
   logic              out_ready;
   logic              clr_erros;
   logic              erro_sticky;
   logic [CNT_W-1:0]  cont_erros;

   // Second instance in odd-parity mode, fed with the same stimulus.
   logic              in_ready_o;
   logic              out_valid_o;
   logic [DATA_W-1:0] out_dado_o;
   logic              out_erro_o;
   logic              erro_sticky_o;
   logic [CNT_W-1:0]  cont_erros_o;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   bit              m_valid;
   bit [DATA_W-1:0] m_dado;
   bit              m_erro;
   bit              m_erro_odd;
   bit              m_sticky;
   int              m_cnt;

   always #5 clk = ~clk;

   paridade_stream #(.DATA_W(DATA_W), .PAR_ODD(0), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_dado(in_dado),
      .in_ready(in_ready), .out_valid(out_valid), .out_dado(out_dado),
      .out_erro(out_erro), .out_ready(out_ready), .clr_erros(clr_erros),
      .erro_sticky(erro_sticky), .cont_erros(cont_erros)
   );

   paridade_stream #(.DATA_W(DATA_W), .PAR_ODD(1), .CNT_W(CNT_W)) u_dut_odd (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_dado(in_dado),
      .in_ready(in_ready_o), .out_valid(out_valid_o), .out_dado(out_dado_o),
      .out_erro(out_erro_o), .out_ready(out_ready), .clr_erros(clr_erros),
      .erro_sticky(erro_sticky_o), .cont_erros(cont_erros_o)
   );

   // A word is in error when its count of ones (parity bit included)
   // does not match the selected parity.
   function automatic bit par_err(input logic [DATA_W:0] w, input int odd);
      return (($countones(w) + odd) % 2) == 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_valid = 0; m_dado = '0; m_erro = 0; m_erro_odd = 0;
      m_sticky = 0; m_cnt = 0;
   endtask

   // Checks every output against the model.
   task automatic chk_outputs(input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      chk({tag, ".out_valid_odd"}, 32'(out_valid_o), 32'(m_valid));
      if (m_valid) begin
         chk({tag, ".out_dado"}, 32'(out_dado), 32'(m_dado));
         chk({tag, ".out_erro"}, 32'(out_erro), 32'(m_erro));
         chk({tag, ".out_erro_odd"}, 32'(out_erro_o), 32'(m_erro_odd));
      end
      chk({tag, ".erro_sticky"}, 32'(erro_sticky), 32'(m_sticky));
      chk({tag, ".cont_erros"}, 32'(cont_erros), 32'(m_cnt));
   endtask

   // One clock cycle. Starts and ends 1 time unit after a rising edge.
   task automatic cycle(input string tag, input logic v, input logic [DATA_W:0] d,
                        input logic ordy, input logic clr);
      bit acc;
      in_valid = v; in_dado = d; out_ready = ordy; clr_erros = clr;
      #1;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || ordy));
      acc = v && (!m_valid || ordy);
      @(posedge clk);
      if (acc) begin
         m_valid    = 1;
         m_dado     = d[DATA_W-1:0];
         m_erro     = par_err(d, 0);
         m_erro_odd = par_err(d, 1);
      end else if (ordy) begin
         m_valid = 0;
      end
      if (clr) begin
         m_sticky = 0;
         m_cnt    = 0;
      end
      if (acc && par_err(d, 0)) begin
         m_sticky = 1;
`ifdef PARIDADE_STREAM_CONTADOR_EN
         if (m_cnt < CNT_MAX) m_cnt++;
`endif
      end
      #1;
      chk_outputs(tag);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_dado = '0; out_ready = 1'b0; clr_erros = 1'b0;
      model_reset();
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Good even-parity word.
      cycle("w003", 1, 9'h003, 1, 0);
      chk("w003.dado_const", 32'(out_dado), 32'h03);
      // Single one: error in even mode, clean in odd mode.
      cycle("w001", 1, 9'h001, 1, 0);
      chk("w001.erro_even", 32'(out_erro), 32'd1);
      chk("w001.erro_odd", 32'(out_erro_o), 32'd0);
      cycle("drain", 0, 9'h000, 1, 0);

      // Back-to-back words with a stall starting on the second cycle.
      cycle("b2b.a", 1, 9'h0A5, 1, 0);
      for (int i = 0; i < 4; i++) begin
         cycle("b2b.stall", 1, 9'h15A, 0, 0);
         chk("b2b.hold", 32'(out_dado), 32'hA5);
      end
      cycle("b2b.b", 1, 9'h15A, 1, 0);
      chk("b2b.b_shown", 32'(out_dado), 32'h5A);
      cycle("b2b.c", 1, 9'h0C3, 1, 0);
      cycle("b2b.d", 1, 9'h13C, 1, 0);
      cycle("b2b.drain", 0, 9'h000, 1, 0);
      chk("b2b.empty", 32'(out_valid), 32'd0);

      // Clear with no new error.
      cycle("clr", 0, 9'h000, 1, 1);

      // Saturation, then clear coinciding with an erroneous acceptance.
      for (int i = 0; i < 300; i++) cycle("sat", 1, 9'h001, 1, 0);
`ifdef PARIDADE_STREAM_CONTADOR_EN
      chk("sat.max", 32'(cont_erros), 32'(CNT_MAX));
`else
      chk("sat.zero", 32'(cont_erros), 32'd0);
`endif
      cycle("sat.hold", 1, 9'h001, 1, 0);
      cycle("clr_err", 1, 9'h001, 1, 1);
      chk("clr_err.sticky", 32'(erro_sticky), 32'd1);

      // Randomized traffic.
      for (int i = 0; i < 250; i++) begin
         cycle("rnd", ($urandom % 4) != 0, 9'($urandom), ($urandom % 3) != 0,
               ($urandom % 16) == 0);
      end

      // Reset mid-stall: outputs drop without a clock edge.
      cycle("pre_rst.a", 1, 9'h001, 1, 0);
      cycle("pre_rst.stall", 1, 9'h0FF, 0, 0);
      chk("pre_rst.valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst.in_ready", 32'(in_ready), 32'd1);
      chk_outputs("async_rst");
      // No word is accepted while reset is held across an edge.
      @(posedge clk);
      #1;
      chk_outputs("rst_edge");
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk_outputs("post_rst");
      cycle("post_rst.w", 1, 9'h181, 1, 0);
      cycle("post_rst.drain", 0, 9'h000, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/paridade_stream.md
PARIDADE_STREAM -- requirements
Module: paridade_stream

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the payload width in bits (minimum 1).
REQ-002 The block SHALL have parameter PAR_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the error-counter width in bits (minimum 1).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_dado  input  DATA_W+1  word; in_dado[DATA_W] is the parity bit, in_dado[DATA_W-1:0] is the payload.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 out_valid  output  1  checked word available.
REQ-010 out_dado  output  DATA_W  payload of the checked word, parity bit stripped.
REQ-011 out_erro  output  1  parity-error flag for the word on out_dado.
REQ-012 out_ready  input  1  downstream accepts the output word.
REQ-013 clr_erros  input  1  synchronous clear of error statistics.
REQ-014 erro_sticky  output  1  set once any accepted word fails its parity check.
REQ-015 cont_erros  output  CNT_W  saturating count of accepted words with parity error.

Function
REQ-016 A word SHALL be accepted in a cycle where in_valid=1 and in_ready=1, and only then.
REQ-017 in_ready SHALL be combinationally equal to (!out_valid || out_ready), so there is one output register and no stall bubble.
REQ-018 An accepted word SHALL appear on out_dado/out_erro with out_valid=1 in the next cycle, for a latency of exactly 1 clock.
REQ-019 out_erro SHALL equal XOR of all DATA_W+1 bits of in_dado, XORed with PAR_ODD.
REQ-020 A word SHALL be retired in a cycle where out_valid=1 and out_ready=1.
REQ-021 When a word is retired with no new acceptance in the same cycle, out_valid SHALL drop to 0 next cycle.
REQ-022 When a word is retired and a new word is accepted in the same cycle, out_valid SHALL stay 1 and the output SHALL show the new word.
REQ-023 While out_valid=1 and out_ready=0, out_dado and out_erro SHALL hold stable, and in_ready SHALL be 0.
REQ-024 out_dado and out_erro SHALL change only on acceptance; when out_valid=0 their values are don't-care.
REQ-025 erro_sticky SHALL set on acceptance of an erroneous word and SHALL hold until clr_erros or reset.
REQ-026 cont_erros SHALL increment by 1 on acceptance of an erroneous word and SHALL saturate at 2^CNT_W-1, with no wrap.
REQ-027 clr_erros=1 SHALL clear cont_erros and erro_sticky at the next edge.
REQ-028 If clr_erros coincides with acceptance of an erroneous word, the result SHALL be cont_erros=1 and erro_sticky=1: the clear is applied first, then the new error.
REQ-029 clr_erros SHALL NOT affect the data path or the handshake.

Reset
REQ-030 With rst_n=0, out_valid, out_dado, out_erro, erro_sticky and cont_erros SHALL be 0 immediately, without waiting for clk.
REQ-031 A word held in the output register when reset asserts SHALL be discarded.
REQ-032 During reset in_ready SHALL read 1; no word is accepted while rst_n=0.
REQ-033 Normal operation SHALL resume on the first rising edge after rst_n deasserts.

Configuration
REQ-034 The macro PARIDADE_STREAM_CONTADOR_EN SHALL control whether the error counter is compiled in.
REQ-035 With PARIDADE_STREAM_CONTADOR_EN defined, cont_erros SHALL behave per REQ-026 to REQ-028.
REQ-036 Without PARIDADE_STREAM_CONTADOR_EN, the counter register SHALL be absent and cont_erros SHALL be the constant 0.
REQ-037 Without PARIDADE_STREAM_CONTADOR_EN, the port list, the handshake and erro_sticky SHALL be unchanged.

Verification (DATA_W=8, CNT_W=8)
REQ-038 Even parity, in_dado=9'h003 accepted with out_ready=1 -> next cycle out_valid=1, out_dado=8'h03, out_erro=0; cont_erros stays 0.
REQ-039 Even parity, in_dado=9'h001 -> out_erro=1, erro_sticky=1, cont_erros=1; with PAR_ODD=1 the same word -> out_erro=0.
REQ-040 Back-to-back 4 words with out_ready=0 from cycle 2 -> in_ready=0, first word held stable; out_ready=1 then retires it with no lost or duplicated word.
REQ-041 300 erroneous words (counter macro defined) -> cont_erros=8'hFF stable; clr_erros with an erroneous acceptance in the same cycle -> cont_erros=1.
REQ-042 rst_n pulsed low mid-stall with out_valid=1 -> all outputs 0 asynchronously, in_ready=1; without the macro cont_erros=0 throughout.
